seg_execute_muldiv: RTL and testbench
=====================================

SEG_EXECUTE_MULDIV -- requirements
Module: seg_execute_muldiv

Interface
REQ-001 The block SHALL have parameter LEN, default 32, as the operand and HI/LO width; legal values are 4 to 64.
REQ-002 The block SHALL have parameter NB_MDOP, default 4, as the width of the mul/div opcode.
REQ-003 The block SHALL have port i_clk, input, 1 bit: clock; all state updates on the rising edge.
REQ-004 The block SHALL have port i_rst, input, 1 bit: reset, synchronous, active-low.
REQ-005 The block SHALL have port i_valid, input, 1 bit: the EX-stage instruction is valid.
REQ-006 The block SHALL have port i_flush, input, 1 bit: squash the current EX instruction and abort any operation in flight.
REQ-007 The block SHALL have port i_md_op, input, NB_MDOP bits, encoded as follows: 0 NOP, 1 MULT, 2 MULTU, 3 DIV, 4 DIVU, 5 MFHI, 6 MFLO, 7 MTHI, 8 MTLO; every other code is NOP.
REQ-008 The block SHALL have port i_data_a, input, LEN bits: rs operand, already forwarded.
REQ-009 The block SHALL have port i_data_b, input, LEN bits: rt operand, already forwarded.
REQ-010 The block SHALL have port o_result, output, LEN bits: MFHI/MFLO read data.
REQ-011 The block SHALL have the following output ports:
- o_hi, output, LEN bits: architectural HI register.
- o_lo, output, LEN bits: architectural LO register.
REQ-012 The block SHALL have port o_busy, output, 1 bit: high whenever the FSM is not IDLE.
REQ-013 The block SHALL have port o_stall, output, 1 bit: request to the hazard unit to freeze IF/ID/EX.
REQ-014 The block SHALL have port o_done, output, 1 bit: one-cycle pulse after HI/LO is written by MULT, MULTU, DIV or DIVU.

Function
REQ-015 The FSM SHALL have three states: IDLE, BUSY and FIX.
REQ-016 An operation SHALL be accepted in IDLE when all of the following hold: i_valid=1, i_flush=0 and i_md_op is in 1..4.
- On acceptance the FSM moves to BUSY.
- On acceptance the block loads |a| and |b| (signed ops) or a and b (unsigned ops) and latches the result sign.
- On acceptance the iteration counter is set to LEN.
REQ-017 In BUSY, each cycle SHALL perform one iteration and decrement the counter.
- Multiply: shift-add, producing a 2*LEN-bit product.
- Divide: restoring divide, producing quotient and remainder.
- The FSM moves to FIX on the cycle the counter reaches 1.
REQ-018 In FIX, the block SHALL apply sign correction, write HI/LO, pulse o_done and return to IDLE.
- The quotient is negated if the signs of a and b differ.
- The remainder takes the sign of a.
- HI/LO are written on edge LEN+1 counted from the accept edge.
REQ-019 MULT and MULTU SHALL write HI = product[2*LEN-1:LEN] and LO = product[LEN-1:0].
REQ-020 DIV and DIVU SHALL write LO = quotient and HI = remainder.
REQ-021 A divisor of zero SHALL be detected at accept; FIX then writes LO = all ones and HI = i_data_a as captured, for both signed and unsigned divides.
REQ-022 Signed DIV of most-negative by -1 SHALL yield LO = most-negative and HI = 0, with no exception.
REQ-023 MTHI and MTLO SHALL write HI or LO from i_data_a on the edge when i_valid=1, i_flush=0 and the FSM is IDLE.
REQ-024 o_result SHALL equal o_hi for MFHI, o_lo for MFLO, and 0 otherwise; it is combinational.
REQ-025 o_stall SHALL equal i_valid AND (i_md_op is in 1..8) AND (FSM is not IDLE); it is combinational, and no op is accepted while it is high.
REQ-026 i_flush=1 in BUSY or FIX SHALL return the FSM to IDLE on the next edge, leave HI/LO unchanged and suppress o_done.
REQ-027 i_flush=1 in the same cycle as an accept condition SHALL block the accept.
REQ-028 Non-md instructions (i_md_op=NOP) SHALL never cause a stall and SHALL never change state.

Reset
REQ-029 While i_rst=0 at an edge, the block SHALL force the FSM to IDLE, the counter to 0, o_hi and o_lo to 0, o_done to 0, and o_busy to 0; this has priority over i_flush and any accept.
REQ-030 A reset asserted mid-operation SHALL abort the operation, and HI/LO SHALL read 0 after the reset edge.

Verification
REQ-031 The bench SHALL drive MULTU a=0xFFFFFFFF, b=0xFFFFFFFF -> require o_hi=0xFFFFFFFE, o_lo=0x00000001 and o_done high 33 edges after accept, with o_busy high for 33 cycles.
REQ-032 The bench SHALL drive MULT a=-3, b=7, then MFLO -> require o_hi=0xFFFFFFFF, o_lo=0xFFFFFFEB and o_result=0xFFFFFFEB.
REQ-033 The bench SHALL drive DIV a=-7, b=2 -> require LO=0xFFFFFFFD and HI=0xFFFFFFFF; then DIV a=0x80000000, b=-1 -> require LO=0x80000000 and HI=0.
REQ-034 The bench SHALL drive DIVU a=0x1234, b=0 -> require LO=0xFFFFFFFF and HI=0x00001234.
REQ-035 The bench SHALL drive MULTU and then i_valid with MFHI one cycle later -> require o_stall=1 until the cycle after o_done, and MFHI then returns the new HI.
REQ-036 The bench SHALL pulse i_flush on the 10th BUSY cycle, after MTHI 0xA5A5A5A5 -> require o_busy=0 next cycle, HI=0xA5A5A5A5 and no o_done; then assert i_rst=0 mid-op -> require HI=LO=0 and FSM in IDLE.

Source files
------------

// File: rtl/seg_execute_muldiv.sv
// rtl/seg_execute_muldiv.sv - iterative EX-stage multiply/divide unit with HI/LO registers
module seg_execute_muldiv #(
  parameter int LEN     = 32,
  parameter int NB_MDOP = 4
) (
  input  logic               i_clk,
  input  logic               i_rst,
  input  logic               i_valid,
  input  logic               i_flush,
  input  logic [NB_MDOP-1:0] i_md_op,
  input  logic [LEN-1:0]     i_data_a,
  input  logic [LEN-1:0]     i_data_b,
  output logic [LEN-1:0]     o_result,
  output logic [LEN-1:0]     o_hi,
  output logic [LEN-1:0]     o_lo,
  output logic               o_busy,
  output logic               o_stall,
  output logic               o_done
);

  localparam int CW = $clog2(LEN + 1);

  localparam logic [NB_MDOP-1:0] OP_MULT  = NB_MDOP'(1);
  localparam logic [NB_MDOP-1:0] OP_MULTU = NB_MDOP'(2);
  localparam logic [NB_MDOP-1:0] OP_DIV   = NB_MDOP'(3);
  localparam logic [NB_MDOP-1:0] OP_DIVU  = NB_MDOP'(4);
  localparam logic [NB_MDOP-1:0] OP_MFHI  = NB_MDOP'(5);
  localparam logic [NB_MDOP-1:0] OP_MFLO  = NB_MDOP'(6);
  localparam logic [NB_MDOP-1:0] OP_MTHI  = NB_MDOP'(7);
  localparam logic [NB_MDOP-1:0] OP_MTLO  = NB_MDOP'(8);

  typedef enum logic [1:0] {S_IDLE, S_BUSY, S_FIX} state_t;

  state_t              state_q, state_d;
  logic [CW-1:0]       cnt_q, cnt_d;
  logic [LEN-1:0]      hi_q, hi_d, lo_q, lo_d;
  logic [LEN-1:0]      a_q, a_d, b_q, b_d, a_raw_q, a_raw_d;
  logic [2*LEN-1:0]    p_q, p_d;
  logic                is_div_q, is_div_d, dz_q, dz_d;
  logic                neg_q, neg_d, rneg_q, rneg_d;
  logic                done_q, done_d;

  logic                start, signed_op, a_neg, b_neg, is_div_op;
  logic [LEN-1:0]      a_abs, b_abs;
  logic [LEN:0]        mul_sum, rem_sh, rem_sub;
  logic                q_bit;
  logic [2*LEN-1:0]    prod_fix;

  // Accept check: only long-running ops start the FSM
  assign start = (state_q == S_IDLE) && i_valid && !i_flush &&
                 (i_md_op == OP_MULT || i_md_op == OP_MULTU ||
                  i_md_op == OP_DIV  || i_md_op == OP_DIVU);

  assign o_busy  = (state_q != S_IDLE);
  assign o_stall = i_valid && (32'(i_md_op) >= 32'd1) && (32'(i_md_op) <= 32'd8) &&
                   (state_q != S_IDLE);
  assign o_hi    = hi_q;
  assign o_lo    = lo_q;
  assign o_done  = done_q;
  assign o_result = (i_md_op == OP_MFHI) ? hi_q :
                    (i_md_op == OP_MFLO) ? lo_q : '0;

  // Next-state, iteration datapath and HI/LO write selection
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    hi_d      = hi_q;
    lo_d      = lo_q;
    a_d       = a_q;
    b_d       = b_q;
    a_raw_d   = a_raw_q;
    p_d       = p_q;
    is_div_d  = is_div_q;
    dz_d      = dz_q;
    neg_d     = neg_q;
    rneg_d    = rneg_q;
    done_d    = 1'b0;

    signed_op = (i_md_op == OP_MULT) || (i_md_op == OP_DIV);
    is_div_op = (i_md_op == OP_DIV) || (i_md_op == OP_DIVU);
    a_neg     = signed_op && i_data_a[LEN-1];
    b_neg     = signed_op && i_data_b[LEN-1];
    a_abs     = a_neg ? -i_data_a : i_data_a;
    b_abs     = b_neg ? -i_data_b : i_data_b;

    // shift-add step: conditionally add multiplicand to upper half, shift right
    mul_sum   = {1'b0, p_q[2*LEN-1:LEN]} + ({1'b0, a_q} & {(LEN+1){p_q[0]}});
    // restoring divide step: shift next dividend bit into the partial remainder
    rem_sh    = {p_q[2*LEN-1:LEN], p_q[LEN-1]};
    q_bit     = (rem_sh >= {1'b0, b_q});
    rem_sub   = q_bit ? (rem_sh - {1'b0, b_q}) : rem_sh;
    prod_fix  = neg_q ? -p_q : p_q;

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d  = S_BUSY;
          cnt_d    = CW'(LEN);
          a_d      = a_abs;
          b_d      = b_abs;
          a_raw_d  = i_data_a;
          is_div_d = is_div_op;
          dz_d     = (i_data_b == '0);
          neg_d    = a_neg ^ b_neg;
          rneg_d   = a_neg;
          p_d      = is_div_op ? {{LEN{1'b0}}, a_abs} : {{LEN{1'b0}}, b_abs};
        end else if (i_valid && !i_flush) begin
          if (i_md_op == OP_MTHI) hi_d = i_data_a;
          if (i_md_op == OP_MTLO) lo_d = i_data_a;
        end
      end
      S_BUSY: begin
        if (i_flush) begin
          state_d = S_IDLE;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q - CW'(1);
          if (is_div_q) p_d = {rem_sub[LEN-1:0], p_q[LEN-2:0], q_bit};
          else          p_d = {mul_sum, p_q[LEN-1:1]};
          if (cnt_q == CW'(1)) state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_IDLE;
        cnt_d   = '0;
        if (!i_flush) begin
          done_d = 1'b1;
          if (dz_q) begin
            hi_d = a_raw_q;
            lo_d = '1;
          end else if (is_div_q) begin
            lo_d = neg_q  ? -p_q[LEN-1:0]       : p_q[LEN-1:0];
            hi_d = rneg_q ? -p_q[2*LEN-1:LEN]   : p_q[2*LEN-1:LEN];
          end else begin
            hi_d = prod_fix[2*LEN-1:LEN];
            lo_d = prod_fix[LEN-1:0];
          end
        end
      end
      default: begin
        state_d = S_IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and datapath registers; reset overrides flush and accept
  always_ff @(posedge i_clk) begin
    if (!i_rst) begin
      state_q  <= S_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      a_q      <= '0;
      b_q      <= '0;
      a_raw_q  <= '0;
      p_q      <= '0;
      is_div_q <= 1'b0;
      dz_q     <= 1'b0;
      neg_q    <= 1'b0;
      rneg_q   <= 1'b0;
      done_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      a_q      <= a_d;
      b_q      <= b_d;
      a_raw_q  <= a_raw_d;
      p_q      <= p_d;
      is_div_q <= is_div_d;
      dz_q     <= dz_d;
      neg_q    <= neg_d;
      rneg_q   <= rneg_d;
      done_q   <= done_d;
    end
  end

endmodule

// File: tb/tb_seg_execute_muldiv.sv
// tb/tb_seg_execute_muldiv.sv - scoreboard bench for seg_execute_muldiv
module tb_seg_execute_muldiv;

  localparam int LEN = 32;
  localparam int NB  = 4;

  logic            i_clk = 1'b0;
  logic            i_rst;
  logic            i_valid;
  logic            i_flush;
  logic [NB-1:0]   i_md_op;
  logic [LEN-1:0]  i_data_a, i_data_b;
  logic [LEN-1:0]  o_result, o_hi, o_lo;
  logic            o_busy, o_stall, o_done;

  seg_execute_muldiv #(.LEN(LEN), .NB_MDOP(NB)) dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_valid(i_valid), .i_flush(i_flush),
    .i_md_op(i_md_op), .i_data_a(i_data_a), .i_data_b(i_data_b),
    .o_result(o_result), .o_hi(o_hi), .o_lo(o_lo),
    .o_busy(o_busy), .o_stall(o_stall), .o_done(o_done)
  );

  always #5 i_clk = ~i_clk;

  typedef struct {
    logic [LEN-1:0] hi;
    logic [LEN-1:0] lo;
    int             cyc;
  } exp_t;

  exp_t sb[$];
  int   n_chk  = 0;
  int   n_fail = 0;
  int   cyc    = 0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge i_clk);
    #1;
  endtask

  always @(posedge i_clk) cyc++;

  // Monitor: every o_done pulse pops one expected HI/LO pair and its due edge
  initial begin
    exp_t e;
    forever begin
      @(posedge i_clk);
      #2;
      if (o_done) begin
        if (sb.size() == 0) begin
          check("unexpected_done", 64'(o_done), 64'd0);
        end else begin
          e = sb.pop_front();
          check("sb_hi", 64'(o_hi), 64'(e.hi));
          check("sb_lo", 64'(o_lo), 64'(e.lo));
          check("sb_done_edge", 64'(cyc), 64'(e.cyc));
        end
      end
    end
  end

  task automatic idle_inputs();
    i_valid = 1'b0; i_flush = 1'b0; i_md_op = '0; i_data_a = '0; i_data_b = '0;
  endtask

  // Issues one op, pushes its expectation, waits for done; returns busy-cycle count
  task automatic do_op(input logic [NB-1:0] op, input logic [LEN-1:0] a, input logic [LEN-1:0] b,
                       input logic [LEN-1:0] eh, input logic [LEN-1:0] el, output int busy_cnt);
    exp_t e;
    int   n;
    i_valid = 1'b1; i_md_op = op; i_data_a = a; i_data_b = b;
    e.hi = eh; e.lo = el; e.cyc = cyc + 1 + 33;
    sb.push_back(e);
    tick();
    idle_inputs();
    busy_cnt = 0;
    n = 0;
    while (!o_done && n < 60) begin
      if (o_busy) busy_cnt++;
      tick();
      n++;
    end
    if (n >= 60) check("done_timeout", 64'(o_done), 64'd1);
  endtask

  initial begin
    int bc, n, stall_bad;
    logic saw_done;
    idle_inputs();
    i_rst = 1'b0;
    tick(); tick();
    check("rst_hi", 64'(o_hi), 64'd0);
    check("rst_lo", 64'(o_lo), 64'd0);
    check("rst_busy", 64'(o_busy), 64'd0);
    check("rst_done", 64'(o_done), 64'd0);
    i_rst = 1'b1;
    tick();

    do_op(4'd2, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, bc);
    check("multu_busy_cycles", 64'(bc), 64'd33);

    do_op(4'd1, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, bc);
    i_valid = 1'b1; i_md_op = 4'd6; #1;
    check("mflo_result", 64'(o_result), 64'hFFFFFFEB);
    check("mflo_no_stall", 64'(o_stall), 64'd0);
    tick(); idle_inputs();

    do_op(4'd3, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, bc);
    do_op(4'd3, 32'h80000000, 32'hFFFFFFFF, 32'h00000000, 32'h80000000, bc);
    do_op(4'd4, 32'h00001234, 32'd0, 32'h00001234, 32'hFFFFFFFF, bc);
    do_op(4'd3, 32'hFFFFFFF9, 32'd0, 32'hFFFFFFF9, 32'hFFFFFFFF, bc);
    do_op(4'd4, 32'd100, 32'd7, 32'd2, 32'd14, bc);
    do_op(4'd3, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, bc);
    do_op(4'd1, 32'hFFFFFFFB, 32'hFFFFFFFA, 32'd0, 32'd30, bc);

    // MULTU followed by a stalled MFHI
    begin
      exp_t e;
      i_valid = 1'b1; i_md_op = 4'd2; i_data_a = 32'h00010000; i_data_b = 32'h00010000;
      e.hi = 32'd1; e.lo = 32'd0; e.cyc = cyc + 1 + 33;
      sb.push_back(e);
      tick();
      i_md_op = 4'd5; i_data_a = '0; i_data_b = '0;
      #1;
      stall_bad = 0; n = 0;
      while (!o_done && n < 60) begin
        if (o_stall !== 1'b1) stall_bad++;
        tick(); n++;
      end
      check("stall_while_busy_errors", 64'(stall_bad), 64'd0);
      check("stall_wait_bounded", 64'(n < 60), 64'd1);
      check("stall_released", 64'(o_stall), 64'd0);
      check("mfhi_new_hi", 64'(o_result), 64'd1);
      tick(); idle_inputs();
    end

    // Flush coinciding with an accept blocks it
    i_valid = 1'b1; i_md_op = 4'd1; i_data_a = 32'd3; i_data_b = 32'd3; i_flush = 1'b1;
    tick(); idle_inputs();
    check("flush_blocks_accept", 64'(o_busy), 64'd0);

    // MTHI then flush on the 10th BUSY cycle
    i_valid = 1'b1; i_md_op = 4'd7; i_data_a = 32'hA5A5A5A5;
    tick(); idle_inputs();
    check("mthi_hi", 64'(o_hi), 64'hA5A5A5A5);
    i_valid = 1'b1; i_md_op = 4'd2; i_data_a = 32'd9; i_data_b = 32'd9;
    tick(); idle_inputs();
    for (int k = 0; k < 9; k++) tick();
    i_valid = 1'b1; i_md_op = 4'd0;
    #1;
    check("nop_no_stall", 64'(o_stall), 64'd0);
    check("busy_before_flush", 64'(o_busy), 64'd1);
    i_valid = 1'b0; i_flush = 1'b1;
    tick(); idle_inputs();
    check("flush_busy", 64'(o_busy), 64'd0);
    check("flush_hi_kept", 64'(o_hi), 64'hA5A5A5A5);
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done) saw_done = 1'b1;
      tick();
    end
    check("flush_no_done", 64'(saw_done), 64'd0);

    // Reset mid-operation
    i_valid = 1'b1; i_md_op = 4'd3; i_data_a = 32'd50; i_data_b = 32'd5;
    tick(); idle_inputs();
    for (int k = 0; k < 5; k++) tick();
    i_rst = 1'b0;
    tick();
    check("midrst_hi", 64'(o_hi), 64'd0);
    check("midrst_lo", 64'(o_lo), 64'd0);
    check("midrst_busy", 64'(o_busy), 64'd0);
    i_rst = 1'b1;
    saw_done = 1'b0;
    for (int k = 0; k < 40; k++) begin
      if (o_done || o_busy) saw_done = 1'b1;
      tick();
    end
    check("midrst_stays_idle", 64'(saw_done), 64'd0);
    check("sb_drained", 64'(sb.size()), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
